// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/LSU) arbiter onto one in-order memory port.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on contention (default: data wins).
// Ports: CLK, RST_N (sync, active-low); instr_* fetch side; data_* LSU side;
//        rdata_o/err_o shared response; mem_* downstream memory port.
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i
);

   typedef enum logic {IDLE, WAIT_GNT} state_t;

   localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

   state_t                     state_q, state_d;
   logic                       sel_q, sel_d;
   logic [2:0]                 count_q, count_d;
   logic [MAX_OUTSTANDING-1:0] id_q, id_d;
   logic [2:0]                 wr_idx;
   logic                       arb_data, sel_data;
   logic                       push, pop;

   // Free arbitration result (1 = data side)
`ifdef ARB_ROUND_ROBIN_EN
   logic last_data_q;
   assign arb_data = data_req_i & (~instr_req_i | ~last_data_q);
`else
   assign arb_data = data_req_i;
`endif

   // A stalled request keeps its requester until granted
   assign sel_data = (state_q == WAIT_GNT) ? sel_q : arb_data;

   assign mem_req_o = (instr_req_i | data_req_i) & (count_q < MAX_CNT);
   assign push      = mem_req_o & mem_gnt_i;
   assign pop       = mem_rvalid_i & (count_q != 3'd0);

   assign instr_gnt_o = push & ~sel_data;
   assign data_gnt_o  = push & sel_data;

   // Head of the ID FIFO is always bit 0
   assign instr_rvalid_o = pop & ~id_q[0];
   assign data_rvalid_o  = pop & id_q[0];
   assign rdata_o        = mem_rdata_i;
   assign err_o          = mem_err_i & mem_rvalid_i;

   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (mem_req_o) begin
         if (sel_data) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      unique case (state_q)
         IDLE: begin
            if (mem_req_o & ~mem_gnt_i) begin
               state_d = WAIT_GNT;
               sel_d   = arb_data;
            end
         end
         WAIT_GNT: begin
            if (mem_gnt_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Shift-down FIFO: pop shifts, push lands just past the live entries
   always_comb begin
      id_d    = id_q;
      count_d = count_q;
      wr_idx  = pop ? count_q - 3'd1 : count_q;
      if (pop) begin
         for (int i = 0; i < MAX_OUTSTANDING - 1; i++) id_d[i] = id_q[i+1];
         id_d[MAX_OUTSTANDING-1] = 1'b0;
      end
      if (push) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (wr_idx == 3'(i)) id_d[i] = sel_data;
      end
      if (push & ~pop) count_d = count_q + 3'd1;
      else if (pop & ~push) count_d = count_q - 3'd1;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         count_q <= 3'd0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         count_q <= count_d;
         id_q    <= id_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge CLK) begin
      if (!RST_N) last_data_q <= 1'b0;
      else if (push) last_data_q <= sel_data;
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Covers fetch, contention, stall freeze, full, ordering/error and reset.
module tb_mem_port_arbiter;

   logic        CLK;
   logic        RST_N;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;

   int n_chk  = 0;
   int n_fail = 0;

   mem_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      @(negedge CLK);
   endtask

   task automatic clr();
      instr_req_i  = 1'b0;
      data_req_i   = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
      mem_rdata_i  = 32'h0;
   endtask

   logic [3:0] exp_d;

   initial begin
      RST_N        = 1'b0;
      instr_addr_i = 32'h0;
      data_we_i    = 1'b0;
      data_be_i    = 4'h0;
      data_addr_i  = 32'h0;
      data_wdata_i = 32'h0;
      clr();
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = 4'b0101;
`else
      exp_d = 4'b1111;
`endif

      // Reset state
      tick();
      tick();
      settle();
      check("rst_req", 32'(mem_req_o), 32'h0);
      check("rst_ignt", 32'(instr_gnt_o), 32'h0);
      check("rst_dgnt", 32'(data_gnt_o), 32'h0);
      check("rst_addr", mem_addr_o, 32'h0);
      check("rst_rv", 32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
      tick();
      RST_N = 1'b1;

      // Single fetch
      tick();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h100;
      mem_gnt_i    = 1'b1;
      settle();
      check("f_ignt", 32'(instr_gnt_o), 32'h1);
      check("f_dgnt", 32'(data_gnt_o), 32'h0);
      check("f_addr", mem_addr_o, 32'h100);
      check("f_be", 32'(mem_be_o), 32'hF);
      check("f_we", 32'(mem_we_o), 32'h0);
      tick();
      clr();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h13;
      settle();
      check("f_irv", 32'(instr_rvalid_o), 32'h1);
      check("f_drv", 32'(data_rvalid_o), 32'h0);
      check("f_rdata", rdata_o, 32'h13);
      check("f_err", 32'(err_o), 32'h0);
      tick();
      clr();

      // Contention for 4 cycles, responses overlap to keep count below full
      data_addr_i  = 32'h200;
      data_we_i    = 1'b1;
      data_be_i    = 4'h3;
      data_wdata_i = 32'hDEADBEEF;
      instr_addr_i = 32'h104;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         instr_req_i  = 1'b1;
         data_req_i   = 1'b1;
         mem_gnt_i    = 1'b1;
         mem_rvalid_i = (k > 0);
         settle();
         check($sformatf("c_dgnt%0d", k), 32'(data_gnt_o), 32'(exp_d[k]));
         check($sformatf("c_ignt%0d", k), 32'(instr_gnt_o), 32'(!exp_d[k]));
         check($sformatf("c_addr%0d", k), mem_addr_o,
               exp_d[k] ? 32'h200 : 32'h104);
         check($sformatf("c_wd%0d", k), mem_wdata_o,
               exp_d[k] ? 32'hDEADBEEF : 32'h0);
         if (k > 0)
            check($sformatf("c_drv%0d", k), 32'(data_rvalid_o),
                  32'(exp_d[k-1]));
      end
      tick();
      clr();
      mem_rvalid_i = 1'b1;
      settle();
      check("c_drv_last", 32'(data_rvalid_o), 32'(exp_d[3]));
      check("c_irv_last", 32'(instr_rvalid_o), 32'(!exp_d[3]));
      tick();
      clr();

      // Stall: data waits, fetch rises meanwhile
      data_addr_i = 32'h300;
      data_we_i   = 1'b0;
      data_be_i   = 4'hF;
      data_req_i  = 1'b1;
      settle();
      check("s_addr0", mem_addr_o, 32'h300);
      check("s_dgnt0", 32'(data_gnt_o), 32'h0);
      for (int k = 1; k < 3; k++) begin
         tick();
         instr_req_i = 1'b1;
         settle();
         check($sformatf("s_addr%0d", k), mem_addr_o, 32'h300);
         check($sformatf("s_ignt%0d", k), 32'(instr_gnt_o), 32'h0);
      end
      tick();
      mem_gnt_i = 1'b1;
      settle();
      check("s_dgnt3", 32'(data_gnt_o), 32'h1);
      check("s_ignt3", 32'(instr_gnt_o), 32'h0);
      tick();
      clr();
      mem_rvalid_i = 1'b1;
      settle();
      check("s_drv", 32'(data_rvalid_o), 32'h1);
      tick();
      clr();

      // Stall: fetch waits, data rises but must not steal the port
      instr_addr_i = 32'h400;
      instr_req_i  = 1'b1;
      settle();
      check("s2_addr0", mem_addr_o, 32'h400);
      tick();
      data_req_i = 1'b1;
      settle();
      check("s2_addr1", mem_addr_o, 32'h400);
      check("s2_be1", 32'(mem_be_o), 32'hF);
      tick();
      mem_gnt_i = 1'b1;
      settle();
      check("s2_ignt", 32'(instr_gnt_o), 32'h1);
      check("s2_dgnt", 32'(data_gnt_o), 32'h0);
      tick();
      clr();
      mem_rvalid_i = 1'b1;
      settle();
      check("s2_irv", 32'(instr_rvalid_o), 32'h1);
      tick();
      clr();

      // Full at 2 outstanding, no same-cycle bypass
      instr_req_i = 1'b1;
      mem_gnt_i   = 1'b1;
      settle();
      check("u_g1", 32'(instr_gnt_o), 32'h1);
      tick();
      settle();
      check("u_g2", 32'(instr_gnt_o), 32'h1);
      tick();
      settle();
      check("u_req_full", 32'(mem_req_o), 32'h0);
      check("u_gnt_full", 32'(instr_gnt_o), 32'h0);
      tick();
      mem_rvalid_i = 1'b1;
      settle();
      check("u_req_byp", 32'(mem_req_o), 32'h0);
      check("u_gnt_byp", 32'(instr_gnt_o), 32'h0);
      check("u_irv", 32'(instr_rvalid_o), 32'h1);
      tick();
      mem_rvalid_i = 1'b0;
      settle();
      check("u_req_again", 32'(mem_req_o), 32'h1);
      check("u_gnt_again", 32'(instr_gnt_o), 32'h1);
      tick();
      clr();
      mem_rvalid_i = 1'b1;
      tick();
      tick();
      clr();

      // Ordering and error routing
      instr_req_i = 1'b1;
      mem_gnt_i   = 1'b1;
      settle();
      check("o_igrant", 32'(instr_gnt_o), 32'h1);
      tick();
      instr_req_i = 1'b0;
      data_req_i  = 1'b1;
      settle();
      check("o_dgrant", 32'(data_gnt_o), 32'h1);
      tick();
      clr();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hA5A5A5A5;
      settle();
      check("o_irv", 32'(instr_rvalid_o), 32'h1);
      check("o_err0", 32'(err_o), 32'h0);
      tick();
      mem_err_i = 1'b1;
      settle();
      check("o_drv", 32'(data_rvalid_o), 32'h1);
      check("o_irv2", 32'(instr_rvalid_o), 32'h0);
      check("o_err1", 32'(err_o), 32'h1);
      tick();
      clr();

      // Reset with 2 outstanding, then a stray response
      instr_req_i = 1'b1;
      mem_gnt_i   = 1'b1;
      tick();
      instr_req_i = 1'b0;
      data_req_i  = 1'b1;
      tick();
      clr();
      RST_N = 1'b0;
      tick();
      RST_N        = 1'b1;
      mem_rvalid_i = 1'b1;
      settle();
      check("r_irv", 32'(instr_rvalid_o), 32'h0);
      check("r_drv", 32'(data_rvalid_o), 32'h0);
      check("r_req", 32'(mem_req_o), 32'h0);
      tick();
      clr();
      instr_req_i = 1'b1;
      mem_gnt_i   = 1'b1;
      settle();
      check("r_gnt_after", 32'(instr_gnt_o), 32'h1);
      tick();
      clr();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
